// File: rtl/tx_pkg.sv
// Shared types and constants for the TX cipher stage.
// Optional build macro used by the stage: TX_BYPASS_EN.
package tx_pkg;

   localparam int TX_DATA_W = 32;
   localparam int TX_LEN_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } tx_state_e;

endpackage

// File: rtl/tx_out_slice.sv
// Single-stage AXI-Stream register carrying {sof, eof, data}.
// Fields hold stable while valid is high and ready is low.
module tx_out_slice
   import tx_pkg::*;
#(
   parameter int W = TX_DATA_W
) (
   input  logic         aclk_i,
   input  logic         aresetn_i,
   input  logic         load_i,
   input  logic         sof_i,
   input  logic         eof_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         free_o,
   output logic         valid_o,
   output logic         sof_o,
   output logic         eof_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic         sof_q;
   logic         eof_q;
   logic [W-1:0] data_q;

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign sof_o   = sof_q;
   assign eof_o   = eof_q;
   assign data_o  = data_q;

   // Load a new word, drain on ready, otherwise hold everything.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         sof_q   <= sof_i;
         eof_q   <= eof_i;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/tx_frame_encrypt.sv
// TX cipher stage: XORs plaintext with keystream, adds sof/eof framing.
// Optional macro TX_BYPASS_EN adds a per-frame plaintext bypass input.
module tx_frame_encrypt
   import tx_pkg::*;
#(
   parameter int C_LEN_W = TX_LEN_W
) (
   input  logic                 i_aclk,
   input  logic                 i_aresetn,
   input  logic                 i_enable,
   input  logic [C_LEN_W-1:0]   i_frame_len,
`ifdef TX_BYPASS_EN
   input  logic                 i_bypass,
`endif
   output logic                 s_axis_tready,
   input  logic                 s_axis_tvalid,
   input  logic [TX_DATA_W-1:0] s_axis_tdata,
   input  logic [TX_DATA_W-1:0] i_keystream_data,
   input  logic                 i_keystream_valid,
   output logic                 o_keystream_ready,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tvalid,
   output logic [TX_DATA_W-1:0] m_axis_tdata,
   output logic                 m_axis_sof,
   output logic                 m_axis_eof,
   output logic [31:0]          o_frame_count,
   output logic                 o_error
);

   tx_state_e            state_q, state_d;
   logic [C_LEN_W-1:0]   len_q, len_d;
   logic [C_LEN_W-1:0]   cnt_q, cnt_d;
   logic [31:0]          fcnt_q, fcnt_d;
   logic                 err_q, err_d;
   logic                 byp_q, byp_d;
   logic                 byp_in;
   logic                 out_free;
   logic                 accept;
   logic                 last_word;
   logic                 eof_done;
   logic [TX_DATA_W-1:0] ct;

`ifdef TX_BYPASS_EN
   assign byp_in = i_bypass;
`else
   assign byp_in = 1'b0;
`endif

   assign last_word = (cnt_q == len_q - C_LEN_W'(1));
   assign s_axis_tready = (state_q == ST_STREAM)
                        && (byp_q || i_keystream_valid)
                        && out_free;
   assign accept = s_axis_tready && s_axis_tvalid;
   assign o_keystream_ready = accept && !byp_q;
   assign ct = byp_q ? s_axis_tdata
                     : s_axis_tdata ^ i_keystream_data;
   assign eof_done = m_axis_tvalid && m_axis_tready && m_axis_eof;

   assign o_frame_count = fcnt_q;
   assign o_error = err_q;

   // Frame control registers.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
         byp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         err_q   <= err_d;
         byp_q   <= byp_d;
      end
   end

   // Next-state: start frames only from IDLE, finish on eof handoff.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      byp_d   = byp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               if (i_frame_len != '0) begin
                  state_d = ST_STREAM;
                  len_d   = i_frame_len;
                  cnt_d   = '0;
                  byp_d   = byp_in;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (accept) begin
               cnt_d = cnt_q + C_LEN_W'(1);
               if (last_word) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (eof_done) begin
               fcnt_d  = fcnt_q + 32'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   tx_out_slice #(.W(TX_DATA_W)) u_out (
      .aclk_i    (i_aclk),
      .aresetn_i (i_aresetn),
      .load_i    (accept),
      .sof_i     (cnt_q == '0),
      .eof_i     (last_word),
      .data_i    (ct),
      .ready_i   (m_axis_tready),
      .free_o    (out_free),
      .valid_o   (m_axis_tvalid),
      .sof_o     (m_axis_sof),
      .eof_o     (m_axis_eof),
      .data_o    (m_axis_tdata)
   );

endmodule

// File: tb/tb_tx_frame_encrypt.sv
// Directed bench for tx_frame_encrypt (default build, no bypass).
// Inputs change 1ns after posedge; handshakes are observed on negedge.
module tb_tx_frame_encrypt;

   localparam int LW = 16;
   localparam logic [31:0] KS_C = 32'hA5A5_A5A5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [LW-1:0] flen = '0;
   logic          s_rdy;
   logic          s_vld = 1'b0;
   logic [31:0]   s_dat = '0;
   logic [31:0]   ks_dat = KS_C;
   logic          ks_vld = 1'b1;
   logic          ks_rdy;
   logic          m_rdy = 1'b1;
   logic          m_vld;
   logic [31:0]   m_dat;
   logic          m_sof;
   logic          m_eof;
   logic [31:0]   fcnt;
   logic          err;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] pt_mem [128];
   int          pt_wr = 0;
   int          pt_rd = 0;
   logic [33:0] out_mem [128];
   int          out_n = 0;
   int          ks_cnt = 0;
   bit          ks_inc = 0;
   bit          rdy_mode = 0;
   int          ph = 0;
   bit          hold_v = 0;
   logic [34:0] hold_val = '0;
   int          hold_n = 0;
   int          hold_bad = 0;

   always #5 clk = ~clk;

   tx_frame_encrypt #(.C_LEN_W(LW)) dut (
      .i_aclk            (clk),
      .i_aresetn         (rst_n),
      .i_enable          (en),
      .i_frame_len       (flen),
      .s_axis_tready     (s_rdy),
      .s_axis_tvalid     (s_vld),
      .s_axis_tdata      (s_dat),
      .i_keystream_data  (ks_dat),
      .i_keystream_valid (ks_vld),
      .o_keystream_ready (ks_rdy),
      .m_axis_tready     (m_rdy),
      .m_axis_tvalid     (m_vld),
      .m_axis_tdata      (m_dat),
      .m_axis_sof        (m_sof),
      .m_axis_eof        (m_eof),
      .o_frame_count     (fcnt),
      .o_error           (err)
   );

   // Observe handshakes, keystream strobes and output stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         pt_rd  = pt_wr;
         hold_v = 0;
      end else begin
         if (s_rdy && s_vld) pt_rd++;
         if (ks_rdy) ks_cnt++;
         if (m_vld && m_rdy) begin
            out_mem[out_n % 128] = {m_sof, m_eof, m_dat};
            out_n++;
         end
         if (hold_v) begin
            hold_n++;
            if ({m_vld, m_sof, m_eof, m_dat} !== hold_val)
               hold_bad++;
         end
         hold_v   = m_vld && !m_rdy;
         hold_val = {m_vld, m_sof, m_eof, m_dat};
      end
   end

   // Drive plaintext source, keystream data and downstream ready.
   always @(posedge clk) begin
      #1;
      s_vld  = (pt_rd != pt_wr);
      s_dat  = pt_mem[pt_rd % 128];
      ks_dat = ks_inc ? 32'h1000_0000 + 32'(ks_cnt) : KS_C;
      if (rdy_mode) begin
         m_rdy = (ph == 0);
         ph = (ph == 2) ? 0 : ph + 1;
      end else begin
         m_rdy = 1'b1;
      end
   end

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         pt_mem[pt_wr % 128] = base + 32'(i);
         pt_wr++;
      end
   endtask

   task automatic start_frame(input int len);
      flen = LW'(len);
      en = 1'b1;
      cyc();
      en = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input logic [31:0] n);
      for (int i = 0; i < 400 && fcnt != n; i++) cyc();
      chk(tag, fcnt, n);
      cyc(2);
   endtask

   task automatic wait_acc(input string tag, input int base, input int n);
      for (int i = 0; i < 200 && (pt_rd - base) < n; i++) cyc();
      chk(tag, 64'((pt_rd - base) >= n), 64'd1);
   endtask

   task automatic check_frame(input string tag, input int o0,
                              input int n, input logic [31:0] pt0,
                              input logic [31:0] ks0, input bit inc);
      logic [31:0] ks;
      logic [33:0] exp;
      chk({tag, "_cnt"}, 64'(out_n - o0), 64'(n));
      for (int i = 0; i < n; i++) begin
         ks  = inc ? ks0 + 32'(i) : ks0;
         exp = {i == 0, i == n - 1, (pt0 + 32'(i)) ^ ks};
         chk($sformatf("%s_w%0d", tag, i), out_mem[(o0 + i) % 128], exp);
      end
   endtask

   int o0;
   int k0;
   int p0;

   initial begin
      cyc(3);
      chk("rst_tvalid", m_vld, 0);
      chk("rst_tdata", m_dat, 0);
      chk("rst_sof", m_sof, 0);
      chk("rst_eof", m_eof, 0);
      chk("rst_fcnt", fcnt, 0);
      chk("rst_err", err, 0);
      chk("rst_srdy", s_rdy, 0);
      chk("rst_ksrdy", ks_rdy, 0);
      rst_n = 1'b1;
      cyc(2);

      o0 = out_n; k0 = ks_cnt;
      load(32'h1, 4);
      start_frame(4);
      wait_frames("basic_fcnt", 1);
      check_frame("basic", o0, 4, 32'h1, KS_C, 0);
      chk("basic_w0", out_mem[o0 % 128], {2'b10, 32'hA5A5_A5A4});
      chk("basic_w3", out_mem[(o0 + 3) % 128], {2'b01, 32'hA5A5_A5A1});
      chk("basic_ks", 64'(ks_cnt - k0), 64'd4);

      rdy_mode = 1; hold_n = 0; hold_bad = 0;
      o0 = out_n; k0 = ks_cnt;
      load(32'h1, 4);
      start_frame(4);
      wait_frames("bp_fcnt", 2);
      rdy_mode = 0;
      cyc(2);
      check_frame("bp", o0, 4, 32'h1, KS_C, 0);
      chk("bp_ks", 64'(ks_cnt - k0), 64'd4);
      chk("bp_stalled", 64'(hold_n != 0), 64'd1);
      chk("bp_hold", 64'(hold_bad), 64'd0);

      ks_inc = 1;
      cyc(2);
      o0 = out_n; p0 = pt_rd;
      load(32'hC0DE_0000, 6);
      start_frame(6);
      wait_acc("ks_acc2", p0, 2);
      ks_vld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("ks_stall%0d", i), s_rdy, 0);
         @(posedge clk);
         #1;
      end
      ks_vld = 1'b1;
      wait_frames("ks_fcnt", 3);
      check_frame("ks", o0, 6, 32'hC0DE_0000, 32'h1000_0008, 1);
      ks_inc = 0;
      cyc(2);

      o0 = out_n;
      load(32'h0000_00FF, 1);
      start_frame(1);
      wait_frames("len1_fcnt", 4);
      chk("len1_w0", out_mem[o0 % 128], {2'b11, 32'hA5A5_A55A});
      chk("len1_cnt", 64'(out_n - o0), 64'd1);

      o0 = out_n;
      start_frame(0);
      cyc(3);
      chk("len0_err", err, 1);
      chk("len0_out", 64'(out_n - o0), 64'd0);
      chk("len0_fcnt", fcnt, 4);
      @(negedge clk);
      chk("len0_idle", s_rdy, 0);
      cyc();

      o0 = out_n; p0 = pt_rd;
      load(32'h20, 8);
      flen = LW'(8);
      en = 1'b1;
      wait_acc("mid_acc3", p0, 3);
      flen = LW'(2);
      en = 1'b0;
      wait_frames("mid_fcnt", 5);
      check_frame("mid", o0, 8, 32'h20, KS_C, 0);
      cyc(8);
      chk("mid_fcnt_hold", fcnt, 5);
      chk("mid_no_more", 64'(out_n - o0), 64'd8);
      @(negedge clk);
      chk("mid_idle", s_rdy, 0);
      cyc();

      p0 = pt_rd;
      load(32'h30, 6);
      start_frame(6);
      wait_acc("rst_acc2", p0, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_tvalid", m_vld, 0);
      chk("arst_tdata", m_dat, 0);
      chk("arst_sof", m_sof, 0);
      chk("arst_eof", m_eof, 0);
      chk("arst_fcnt", fcnt, 0);
      chk("arst_err", err, 0);
      chk("arst_srdy", s_rdy, 0);
      chk("arst_ksrdy", ks_rdy, 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      o0 = out_n;
      load(32'h40, 2);
      start_frame(2);
      wait_frames("post_fcnt", 1);
      check_frame("post", o0, 2, 32'h40, KS_C, 0);
      chk("post_sof", out_mem[o0 % 128], {2'b10, 32'hA5A5_A5E5});

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
